// File: rtl/shared_mul_arbiter_pkg.sv
// Shared definitions for the two-requester shared multiplier arbiter.
// Provides the requester count, end-to-end latency and the pipeline stage
// record carried alongside each op through S1/S2.
package mul_share_pkg;

   localparam int NUM_REQ       = 2;
   localparam int MUL_LATENCY   = 3;
   localparam int ID_WIDTH      = $clog2(NUM_REQ);
   // The stage record is shared by every instance, so its tag field is sized
   // for the widest tag supported; narrower tags are zero-padded.
   localparam int MAX_TAG_WIDTH = 8;

   typedef logic [ID_WIDTH-1:0]      req_id_t;
   typedef logic [MAX_TAG_WIDTH-1:0] tag_t;

   typedef struct packed {
      logic    vld;
      req_id_t id;
      tag_t    tag;
   } stage_t;

endpackage

// File: rtl/shared_mul_arbiter_if.sv
// Bundle of requester, result and external-multiplier signals.
//   slave  : the arbiter side (drives rdy, results, multiplier controls, busy)
//   master : the environment side (requesters and the signed multiplier)
interface shared_mul_arbiter_if #(
   parameter int OP_WIDTH  = 32,
   parameter int RES_WIDTH = 64,
   parameter int TAG_WIDTH = 2
);
   logic signed [OP_WIDTH-1:0]  req0_op_a, req0_op_b, req1_op_a, req1_op_b;
   logic [TAG_WIDTH-1:0]        req0_tag, req1_tag;
   logic                        req0_lock, req1_lock;
   logic                        req0_vld, req1_vld;
   logic                        req0_rdy, req1_rdy;
   logic signed [RES_WIDTH-1:0] res0_data, res1_data;
   logic [TAG_WIDTH-1:0]        res0_tag, res1_tag;
   logic                        res0_vld, res1_vld;
   logic signed [OP_WIDTH-1:0]  mul_op_a, mul_op_b;
   logic [1:0]                  mul_ce;
   logic signed [RES_WIDTH-1:0] mul_res;
   logic                        busy;

   modport slave (
      input  req0_op_a, req0_op_b, req1_op_a, req1_op_b,
      input  req0_tag, req1_tag, req0_lock, req1_lock, req0_vld, req1_vld,
      output req0_rdy, req1_rdy,
      output res0_data, res1_data, res0_tag, res1_tag, res0_vld, res1_vld,
      output mul_op_a, mul_op_b, mul_ce,
      input  mul_res,
      output busy
   );

   modport master (
      output req0_op_a, req0_op_b, req1_op_a, req1_op_b,
      output req0_tag, req1_tag, req0_lock, req1_lock, req0_vld, req1_vld,
      input  req0_rdy, req1_rdy,
      input  res0_data, res1_data, res0_tag, res1_tag, res0_vld, res1_vld,
      input  mul_op_a, mul_op_b, mul_ce,
      output mul_res,
      input  busy
   );
endinterface

// File: rtl/shared_mul_arbiter_rr_lock_arbiter.sv
// Round-robin grant between the two requesters with sticky lock.
//   clk, rst : clock, synchronous active-high reset
//   en       : clock enable; 0 suppresses grants and freezes the pointer
//   vld/lock : per-requester request and keep-grant flags
//   gnt      : one-hot grant (doubles as rdy), gnt_id/gnt_any summarise it
module rr_lock_arbiter
   import mul_share_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [NUM_REQ-1:0] vld,
   input  logic [NUM_REQ-1:0] lock,
   output logic [NUM_REQ-1:0] gnt,
   output req_id_t            gnt_id,
   output logic               gnt_any
);

   req_id_t rr_ptr, rr_ptr_next;

   always_ff @(posedge clk) begin
      if (rst) rr_ptr <= '0;
      else     rr_ptr <= rr_ptr_next;
   end

   // A locked grant simply keeps the pointer on its owner, which already
   // gives that requester priority; if it drops vld the other side wins in
   // the same cycle with no extra lock state.
   always_comb begin
      rr_ptr_next = rr_ptr;
      if (gnt_any) rr_ptr_next = lock[gnt_id] ? gnt_id : ~gnt_id;
   end

   // Two requesters: priority goes to rr_ptr, else to the other one.
   always_comb begin
      gnt     = '0;
      gnt_id  = rr_ptr;
      gnt_any = 1'b0;
      if (en && !rst) begin
         if (vld[rr_ptr]) begin
            gnt_id  = rr_ptr;
            gnt_any = 1'b1;
         end else if (vld[~rr_ptr]) begin
            gnt_id  = ~rr_ptr;
            gnt_any = 1'b1;
         end
         gnt[gnt_id] = gnt_any;
      end
   end

endmodule

// File: rtl/shared_mul_arbiter.sv
// Shares one external signed multiplier (input register + multiply stage,
// no output register) between two requesters. Ops are accepted one per
// cycle and results return on the issuing requester's port 3 cycles later.
//   aclk, areset : clock, synchronous active-high reset (overrides aclken)
//   aclken       : global enable; 0 freezes state and drops all handshakes
//   bus          : requests, results, multiplier controls and busy
module shared_mul_arbiter
   import mul_share_pkg::*;
#(
   parameter int OP_WIDTH  = 32,
   parameter int RES_WIDTH = 64,
   parameter int TAG_WIDTH = 2,
   parameter int SIM_DELAY = 1
) (
   input  logic                 aclk,
   input  logic                 areset,
   input  logic                 aclken,
   shared_mul_arbiter_if.slave  bus
);

   // Elaboration-time parameter sanity. SIM_DELAY is accepted for interface
   // compatibility only; this model is zero-delay.
   if (RES_WIDTH != 2 * OP_WIDTH) begin : g_bad_res_width
      $error("RES_WIDTH must equal 2*OP_WIDTH");
   end
   if (TAG_WIDTH > MAX_TAG_WIDTH || TAG_WIDTH < 1) begin : g_bad_tag_width
      $error("TAG_WIDTH out of range");
   end
   if (SIM_DELAY < 0) begin : g_bad_sim_delay
      $error("SIM_DELAY must be non-negative");
   end

   logic [NUM_REQ-1:0][OP_WIDTH-1:0]  op_a, op_b;
   logic [NUM_REQ-1:0][TAG_WIDTH-1:0] tag_in;
   logic [NUM_REQ-1:0]                vld, lock, gnt;
   req_id_t                           gnt_id;
   logic                              gnt_any;

   assign op_a   = {bus.req1_op_a, bus.req0_op_a};
   assign op_b   = {bus.req1_op_b, bus.req0_op_b};
   assign tag_in = {bus.req1_tag, bus.req0_tag};
   assign vld    = {bus.req1_vld, bus.req0_vld};
   assign lock   = {bus.req1_lock, bus.req0_lock};

   rr_lock_arbiter u_arb (
      .clk     (aclk),
      .rst     (areset),
      .en      (aclken),
      .vld     (vld),
      .lock    (lock),
      .gnt     (gnt),
      .gnt_id  (gnt_id),
      .gnt_any (gnt_any)
   );

   assign bus.req0_rdy = gnt[0];
   assign bus.req1_rdy = gnt[1];

   // Operands go straight to the multiplier in the handshake cycle; between
   // handshakes the last issued pair is held so the bus stays quiet.
   logic [OP_WIDTH-1:0] op_a_q, op_b_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         op_a_q <= '0;
         op_b_q <= '0;
      end else if (gnt_any) begin
         op_a_q <= op_a[gnt_id];
         op_b_q <= op_b[gnt_id];
      end
   end

   assign bus.mul_op_a = gnt_any ? op_a[gnt_id] : op_a_q;
   assign bus.mul_op_b = gnt_any ? op_b[gnt_id] : op_b_q;

   // S1 tracks the op sitting in the multiplier input register, S2 the op
   // whose product is on mul_res.
   stage_t s0, s1, s2;

   always_comb begin
      s0     = '0;
      s0.vld = gnt_any;
      s0.id  = gnt_id;
      s0.tag = tag_t'(tag_in[gnt_id]);
   end

   always_ff @(posedge aclk) begin
      if (areset) begin
         s1 <= '0;
         s2 <= '0;
      end else if (aclken) begin
         s1 <= s0;
         s2 <= s1;
      end
   end

   assign bus.mul_ce = {s1.vld & aclken & ~areset, gnt_any};
   assign bus.busy   = s1.vld | s2.vld;

   if (TAG_WIDTH < MAX_TAG_WIDTH) begin : g_tag_pad
      logic unused_tag_bits;
      assign unused_tag_bits = ^s2.tag[MAX_TAG_WIDTH-1:TAG_WIDTH];
   end

   // Result registers: only the issuing requester's port fires; the other
   // port keeps its last data and tag.
   logic [NUM_REQ-1:0]                res_vld_q;
   logic [NUM_REQ-1:0][RES_WIDTH-1:0] res_data_q;
   logic [NUM_REQ-1:0][TAG_WIDTH-1:0] res_tag_q;

   always_ff @(posedge aclk) begin
      if (areset) begin
         res_vld_q  <= '0;
         res_data_q <= '0;
         res_tag_q  <= '0;
      end else if (aclken) begin
         for (int n = 0; n < NUM_REQ; n++) begin
            res_vld_q[n] <= s2.vld && (s2.id == req_id_t'(n));
            if (s2.vld && (s2.id == req_id_t'(n))) begin
               res_data_q[n] <= bus.mul_res;
               res_tag_q[n]  <= s2.tag[TAG_WIDTH-1:0];
            end
         end
      end
   end

   // A pending valid is masked during a stall and shows once enable returns.
   assign bus.res0_vld  = res_vld_q[0] & aclken;
   assign bus.res1_vld  = res_vld_q[1] & aclken;
   assign bus.res0_data = res_data_q[0];
   assign bus.res1_data = res_data_q[1];
   assign bus.res0_tag  = res_tag_q[0];
   assign bus.res1_tag  = res_tag_q[1];

endmodule
